// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared scan states, hex font and segment constants
package seven_seg_pkg;

  // Slot phase: BLANK keeps every anode dark to hide segment switching ghosts
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Segments dark, active-high form {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Active-high hex font, entry n is the glyph for nibble n
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - nibble to active-high seven-segment pattern
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_hi
);

  // Pure table lookup; polarity is applied by the caller
  always_comb begin
    seg_hi = HEX_FONT[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - double-buffered multiplexed seven-segment scan driver
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam bit            HAS_BLANK = (BLANK_CYCLES > 0);

  logic [TW-1:0]         tick, tick_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  scan_state_t           state, state_nxt;
  logic                  slot_end, frame_end;

  logic [VW-1:0]         hold_val, shd_val;
  logic [NUM_DIGITS-1:0] hold_dp, shd_dp;
  logic                  hold_lz, shd_lz;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] digit_keep;
  logic                  lz_seen;
  logic [NUM_DIGITS-1:0] anode_sel;
  logic                  show;

  // Slot/frame position and the phase the next cycle will be in
  always_comb begin
    slot_end  = (tick == TICK_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    tick_nxt  = slot_end ? '0 : tick + TW'(1);
    idx_nxt   = idx;
    if (slot_end) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    state_nxt = (HAS_BLANK && (tick_nxt < BLANK_END)) ? ST_BLANK : ST_DRIVE;
  end

  // Scan counters and BLANK/DRIVE state, kept aligned with tick
  always_ff @(posedge clk) begin
    if (reset) begin
      tick  <= '0;
      idx   <= '0;
      state <= ST_BLANK;
    end else begin
      tick  <= tick_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
    end
  end

  // Holding takes every load; shadow only swaps at the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_val <= '0;
      hold_dp  <= '0;
      hold_lz  <= 1'b0;
      shd_val  <= '0;
      shd_dp   <= '0;
      shd_lz   <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        shd_val <= hold_val;
        shd_dp  <= hold_dp;
        shd_lz  <= hold_lz;
      end
      if (load) begin
        hold_val <= value;
        hold_dp  <= dp;
        hold_lz  <= lz_blank;
        pending  <= 1'b1;
      end else if (frame_end) begin
        pending  <= 1'b0;
      end
    end
  end

  // Digits above the highest nonzero digit go dark when suppression is on
  always_comb begin
    digit_keep = '1;
    lz_seen    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (shd_val[4*i +: 4] != 4'h0) begin
        lz_seen = 1'b1;
      end
      digit_keep[i] = lz_seen || !shd_lz;
    end
  end

  // Current digit selection and its one-hot anode
  always_comb begin
    cur_nib = shd_val[{idx, 2'b00} +: 4];
    cur_dp  = shd_dp[idx];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_sel[i] = (idx == IW'(i));
    end
    show = (state == ST_DRIVE) && digit_keep[idx];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nib),
    .seg_hi (seg_hi)
  );

  // Pin registers with polarity applied; a dark digit also drops seg and dp
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= {NUM_DIGITS{ACTIVE_LOW}};
      seg        <= {7{ACTIVE_LOW}};
      dp_out     <= ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      an         <= (show ? anode_sel : '0) ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg        <= (show ? seg_hi : SEG_OFF) ^ {7{ACTIVE_LOW}};
      dp_out     <= (show && cur_dp) ^ ACTIVE_LOW;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - scoreboard bench for the seven-segment scan driver
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .load       (load),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  typedef struct {
    int               frame;
    logic [3:0][6:0]  segl;
    logic [3:0]       on;
    logic [3:0]       dpl;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int f, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input logic [3:0] on, input logic [3:0] dpl);
    exp_t e;
    e.frame = f;
    e.segl  = {s3, s2, s1, s0};
    e.on    = on;
    e.dpl   = dpl;
    sb.push_back(e);
  endtask

  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load_at(input int k, input logic [15:0] v, input logic [3:0] d, input logic lz);
    go_to(k);
    value    = v;
    dp       = d;
    lz_blank = lz;
    load     = 1'b1;
    go_to(k + 1);
    load     = 1'b0;
  endtask

  // Monitor: tracks pin-frame position and compares pins against the scoreboard
  logic       rst_edge = 1'b0;
  bit         started = 1'b0;
  int         pos = 0;
  int         frame_no = 0;
  int         ncyc = 0;
  int         last_fd = -1;
  int         slot_t, dig;
  logic [3:0] an_on, exp_an;
  logic       exp_dp;

  always @(posedge clk) rst_edge <= reset;

  always @(negedge clk) begin
    if (rst_edge) begin
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp_out", dp_out, 1'b1);
      check("rst_pending", pending, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      if (started && pos != 0) frame_no++;
      started = 1'b1;
      pos     = 0;
      last_fd = -1;
    end else if (started) begin
      slot_t = pos % RD;
      dig    = pos / RD;
      while (sb.size() > 0 && sb[0].frame < frame_no) begin
        check("exp_missed", frame_no, sb[0].frame);
        void'(sb.pop_front());
      end
      an_on = ~an;
      check("one_anode", ($countones(an_on) <= 1), 1'b1);
      check("frame_done", frame_done, (pos == FRAME - 1));
      if (slot_t < BC) begin
        check("blank_an", an, 4'hF);
      end else if (sb.size() > 0 && sb[0].frame == frame_no) begin
        exp_an = sb[0].on[dig] ? ~(4'b0001 << dig) : 4'hF;
        check("drive_an", an, exp_an);
        if (sb[0].on[dig]) begin
          exp_dp = ~sb[0].dpl[dig];
          check("drive_seg", seg, sb[0].segl[dig]);
          check("drive_dp", dp_out, exp_dp);
        end
      end
      if (frame_done) begin
        if (last_fd >= 0) check("fd_period", ncyc - last_fd, FRAME);
        last_fd = ncyc;
      end
      if (pos == FRAME - 1) begin
        if (sb.size() > 0 && sb[0].frame == frame_no) void'(sb.pop_front());
        frame_no++;
        pos = 0;
      end else begin
        pos++;
      end
    end
    ncyc++;
  end

  // Directed stimulus with hand-computed active-low glyphs
  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    push_frame(0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 4'b0000);

    load_at(10, 16'h12AF, 4'b0100, 1'b0);
    check("pending_set", pending, 1'b1);
    push_frame(1, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110, 4'b1111, 4'b0100);
    go_to(31);
    check("pending_hold", pending, 1'b1);
    go_to(33);
    check("pending_clear", pending, 1'b0);

    load_at(40, 16'h0050, 4'b1001, 1'b1);
    push_frame(2, 7'h7F, 7'h7F, 7'b0010010, 7'b1000000, 4'b0011, 4'b1001);

    load_at(70, 16'h0A00, 4'b0000, 1'b1);
    push_frame(3, 7'h7F, 7'b0001000, 7'b1000000, 7'b1000000, 4'b0111, 4'b0000);

    load_at(100, 16'h0000, 4'b0000, 1'b1);
    push_frame(4, 7'h7F, 7'h7F, 7'h7F, 7'b1000000, 4'b0001, 4'b0000);

    load_at(130, 16'h1111, 4'b0000, 1'b0);
    push_frame(5, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 4'b1111, 4'b0000);
    load_at(159, 16'h2222, 4'b0000, 1'b0);
    check("pending_boundary", pending, 1'b1);
    push_frame(6, 7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100, 4'b1111, 4'b0000);
    go_to(191);
    check("pending_until_swap", pending, 1'b1);
    go_to(193);
    check("pending_after_swap", pending, 1'b0);

    load_at(230, 16'h9999, 4'b1111, 1'b0);
    check("pending_before_reset", pending, 1'b1);
    go_to(244);
    reset = 1'b1;
    go_to(245);
    reset = 1'b0;
    cyc   = 0;

    push_frame(8, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 4'b0000);
    push_frame(9, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 4'b0000);
    push_frame(10, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 4'b0000);
    go_to(1);
    check("pending_post_reset", pending, 1'b0);
    go_to(100);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
